ps2_keyboard_rx: RTL



---
 rtl/ps2_pkg.sv | 35 +++
 rtl/ps2_line_filter.sv | 55 +++++
 rtl/ps2_keyboard_rx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard receiver: scancodes, frame states and
// direction bit positions.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam int unsigned DIR_UP    = 3;
  localparam int unsigned DIR_DOWN  = 2;
  localparam int unsigned DIR_LEFT  = 1;
  localparam int unsigned DIR_RIGHT = 0;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } frame_state_e;

  // One-hot direction mask for an arrow scancode, zero for anything else.
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    logic [3:0] m;
    m            = '0;
    m[DIR_UP]    = (code == SC_UP);
    m[DIR_DOWN]  = (code == SC_DOWN);
    m[DIR_LEFT]  = (code == SC_LEFT);
    m[DIR_RIGHT] = (code == SC_RIGHT);
    return m;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 lines and glitch-filters the PS/2 clock, producing a
// one-cycle strobe on each filtered falling edge.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic dat,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mismatch, hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      filt_q     <= 1'b1;
      cnt_q      <= '0;
    end else begin
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_dat;
      dat_sync_q <= dat_meta_q;
      filt_q     <= filt_d;
      cnt_q      <= cnt_d;
    end
  end

  // The filtered level flips on the FILTER_LEN-th consecutive disagreeing sample.
  always_comb begin
    mismatch = (clk_sync_q != filt_q);
    hit      = mismatch && (cnt_q == CW'(FILTER_LEN - 1));
    cnt_d    = '0;
    filt_d   = filt_q;
    if (hit) begin
      filt_d = clk_sync_q;
    end else if (mismatch) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign fall = hit && filt_q;
  assign dat  = dat_sync_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frames bytes off the filtered line and decodes
// extended arrow make/break codes into held direction levels and press pulses.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic [3:0] o_dir,
  output logic [3:0] o_dir_pos
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic dat, fall;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_line_filter (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .ps2_clk(i_ps2_clk),
    .ps2_dat(i_ps2_dat),
    .dat    (dat),
    .fall   (fall)
  );

  frame_state_e  state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic [3:0]    dir_q, dir_d;
  logic [3:0]    dir_pos_q, dir_pos_d;
  logic [3:0]    mask;
  logic          timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      bitcnt_q  <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      dir_q     <= '0;
      dir_pos_q <= '0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      dir_q     <= dir_d;
      dir_pos_q <= dir_pos_d;
    end
  end

  // Frame FSM with inactivity timeout.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    byte_d   = byte_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;

    // Counter restarts on every falling edge; a fall in the same cycle beats the timeout.
    timeout = (state_q != StIdle) && !fall && (tmo_q == TW'(TIMEOUT_CYC - 1));
    if (state_q == StIdle || fall) begin
      tmo_d = '0;
    end else if (tmo_q != TW'(TIMEOUT_CYC)) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = tmo_q;
    end

    case (state_q)
      StIdle: begin
        if (fall && !dat) begin
          state_d  = StData;
          bitcnt_d = '0;
        end
      end
      StData: begin
        if (fall) begin
          shift_d  = {dat, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = dat;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          if (dat && (^{shift_q, par_q})) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (timeout) begin
      state_d = StIdle;
      err_d   = 1'b1;
      shift_d = '0;
    end
  end

  // Scancode decoder, acting on the cycle a byte is presented.
  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    dir_d     = dir_q;
    dir_pos_d = '0;
    mask      = arrow_mask(byte_q);
    if (valid_q) begin
      case (byte_q)
        SC_EXT:  ext_d = 1'b1;
        SC_BRK:  brk_d = 1'b1;
        default: begin
          if (ext_q) begin
            if (brk_q) begin
              dir_d = dir_q & ~mask;
            end else begin
              dir_d     = dir_q | mask;
              dir_pos_d = mask & ~dir_q;
            end
          end
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      endcase
    end else if (err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  assign o_byte       = byte_q;
  assign o_byte_valid = valid_q;
  assign o_frame_err  = err_q;
  assign o_dir        = dir_q;
  assign o_dir_pos    = dir_pos_q;

endmodule
